// File: rtl/alu_gate_lvl.sv
// 4-bit, 16-op switch/LED ALU built from gate-level cells; result registered.
// Latency: 1 clk from stable sw to led. No backpressure; sw sampled every cycle.
// Optional macro ALU_DIV_EN: include the restoring divider for op 3 (else op 3 flags unsupported).

// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// Ripple-carry adder chained from full adder cells.
module rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign co = c[W];
endmodule

module alu_gate_lvl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  output logic [4:0]  led
);
  logic [3:0] a, b, op;
  logic       unused_sw;
  assign a  = sw[3:0];
  assign b  = sw[7:4];
  assign op = sw[11:8];
  // Upper switches carry no function.
  assign unused_sw = ^sw[15:12];

  // Shared adder/subtractor: ADD (b), SUB (~b + 1), INC (0 + 1).
  logic       is_sub, is_inc, add_ci, add_co;
  logic [3:0] add_b, add_s;
  assign is_sub = ~op[3] & ~op[2] & ~op[1] & op[0];
  assign is_inc = &op;
  assign add_b  = (b ^ {4{is_sub}}) & {4{~is_inc}};
  assign add_ci = is_sub | is_inc;
  rca #(.W(4)) u_add (.a(a), .b(add_b), .ci(add_ci), .s(add_s), .co(add_co));

  // Comparator: dedicated A + ~B + 1; carry out means A >= B.
  logic [3:0] cmp_s;
  logic       cmp_co, lt, eq, gt;
  rca #(.W(4)) u_cmp (.a(a), .b(~b), .ci(1'b1), .s(cmp_s), .co(cmp_co));
  assign lt = ~cmp_co;
  assign eq = ~|cmp_s;
  assign gt = cmp_co & ~eq;

  // 4x4 array multiplier: each row adds the next partial product to the shifted running sum.
  logic [3:0] pp0, pp1, pp2, pp3, m1, m2, m3;
  logic       mc1, mc2, mc3;
  logic [7:0] prod;
  logic       mul_f;
  assign pp0 = a & {4{b[0]}};
  assign pp1 = a & {4{b[1]}};
  assign pp2 = a & {4{b[2]}};
  assign pp3 = a & {4{b[3]}};
  rca #(.W(4)) u_m1 (.a({1'b0, pp0[3:1]}), .b(pp1), .ci(1'b0), .s(m1), .co(mc1));
  rca #(.W(4)) u_m2 (.a({mc1, m1[3:1]}),   .b(pp2), .ci(1'b0), .s(m2), .co(mc2));
  rca #(.W(4)) u_m3 (.a({mc2, m2[3:1]}),   .b(pp3), .ci(1'b0), .s(m3), .co(mc3));
  assign prod  = {mc3, m3[3:1], m3[0], m2[0], m1[0], pp0[0]};
  assign mul_f = |prod[7:4];

  // Divider: restoring, one trial subtraction per quotient bit, MSB first.
  logic [3:0] div_r;
  logic       div_f;
`ifdef ALU_DIV_EN
  logic [3:0] div_rem [0:4];
  logic [3:0] div_q;
  logic [3:0] unused_div_rem;
  assign div_rem[0] = 4'd0;
  for (genvar k = 0; k < 4; k++) begin : g_div
    logic [4:0] shf, diff;
    logic       co, unused_msb;
    assign shf = {div_rem[k], a[3-k]};
    rca #(.W(5)) u_sub (.a(shf), .b(~{1'b0, b}), .ci(1'b1), .s(diff), .co(co));
    assign div_q[3-k] = co;
    // Kept remainder is always below B, so 4 bits suffice either way.
    assign div_rem[k+1] = co ? diff[3:0] : shf[3:0];
    assign unused_msb = diff[4];
  end
  assign unused_div_rem = div_rem[4];
  assign div_f = ~|b;
  assign div_r = div_f ? 4'hF : div_q;
`else
  assign div_r = 4'd0;
  assign div_f = 1'b1;
`endif

  // Barrel shifters: stages of 1 and 2, any shift of 4 or more clears.
  logic [3:0] shl1, shl2, shl_r, shr1, shr2, shr_r;
  logic       big_sh;
  assign big_sh = b[3] | b[2];
  assign shl1   = b[0] ? {a[2:0], 1'b0} : a;
  assign shl2   = b[1] ? {shl1[1:0], 2'b00} : shl1;
  assign shl_r  = shl2 & {4{~big_sh}};
  assign shr1   = b[0] ? {1'b0, a[3:1]} : a;
  assign shr2   = b[1] ? {2'b00, shr1[3:2]} : shr1;
  assign shr_r  = shr2 & {4{~big_sh}};

  logic [4:0] led_d, led_q;

  // Result select by opcode.
  always_comb begin
    led_d = 5'd0;
    case (op)
      4'd0:  led_d = {add_co, add_s};
      4'd1:  led_d = {~add_co, add_s};
      4'd2:  led_d = {mul_f, prod[3:0]};
      4'd3:  led_d = {div_f, div_r};
      4'd4:  led_d = {1'b0, a & b};
      4'd5:  led_d = {1'b0, a | b};
      4'd6:  led_d = {1'b0, a ^ b};
      4'd7:  led_d = {1'b0, ~(a & b)};
      4'd8:  led_d = {1'b0, ~(a | b)};
      4'd9:  led_d = {1'b0, ~(a ^ b)};
      4'd10: led_d = {1'b0, shl_r};
      4'd11: led_d = {1'b0, shr_r};
      4'd12: led_d = {4'b0000, gt};
      4'd13: led_d = {4'b0000, lt};
      4'd14: led_d = {4'b0000, eq};
      4'd15: led_d = {add_co, add_s};
    endcase
  end

  // LED register: cleared asynchronously, loads the selected result each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= 5'd0;
    else        led_q <= led_d;
  end

  assign led = led_q;
endmodule

// File: tb/tb_alu_gate_lvl.sv
module tb_alu_gate_lvl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] sw = 16'hFFFF;
  logic [4:0]  led;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] sb_q[$];

  alu_gate_lvl dut (.clk(clk), .rst_n(rst_n), .sw(sw), .led(led));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] sw;
    logic [4:0]  exp;
  } vec_t;

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: led=%b expected %b", name, got, exp);
    end
  endtask

  // Drive at the falling edge, queue the expectation, compare after the rising edge.
  task automatic apply(input string name, input logic [15:0] s, input logic [4:0] exp);
    logic [4:0] e;
    @(negedge clk);
    sw = s;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, led, e);
    end
  endtask

  function automatic logic [4:0] model(input logic [15:0] s);
    logic [3:0] a, b;
    logic [7:0] p;
    logic [4:0] r;
    a = s[3:0];
    b = s[7:4];
    r = 5'd0;
    case (s[11:8])
      4'd0:  r = {1'b0, a} + {1'b0, b};
      4'd1:  r = {1'b0, a} - {1'b0, b};
      4'd2:  begin p = a * b; r = {(p[7:4] != 4'd0), p[3:0]}; end
`ifdef ALU_DIV_EN
      4'd3:  r = (b == 4'd0) ? 5'h1F : {1'b0, a / b};
`else
      4'd3:  r = 5'h10;
`endif
      4'd4:  r = {1'b0, a & b};
      4'd5:  r = {1'b0, a | b};
      4'd6:  r = {1'b0, a ^ b};
      4'd7:  r = {1'b0, ~(a & b)};
      4'd8:  r = {1'b0, ~(a | b)};
      4'd9:  r = {1'b0, ~(a ^ b)};
      4'd10: r = (b >= 4) ? 5'd0 : {1'b0, 4'(a << b)};
      4'd11: r = (b >= 4) ? 5'd0 : {1'b0, a >> b};
      4'd12: r = {4'd0, a > b};
      4'd13: r = {4'd0, a < b};
      4'd14: r = {4'd0, a == b};
      4'd15: r = {1'b0, a} + 5'd1;
    endcase
    return r;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[$];
    logic [4:0] held;
    vt.push_back('{"add_4_3",    16'h0034, 5'h07});
    vt.push_back('{"add_9_8",    16'h0089, 5'h11});
    vt.push_back('{"sub_3_5",    16'h0153, 5'h1E});
    vt.push_back('{"sub_5_3",    16'h0135, 5'h02});
    vt.push_back('{"sub_0_15",   16'h01F0, 5'h11});
    vt.push_back('{"mul_7_3",    16'h0237, 5'h15});
    vt.push_back('{"mul_15_15",  16'h02FF, 5'h11});
    vt.push_back('{"mul_3_5",    16'h0253, 5'h0F});
`ifdef ALU_DIV_EN
    vt.push_back('{"div_6_2",    16'h0326, 5'h03});
    vt.push_back('{"div_6_0",    16'h0306, 5'h1F});
    vt.push_back('{"div_15_4",   16'h034F, 5'h03});
`else
    vt.push_back('{"div_6_2",    16'h0326, 5'h10});
    vt.push_back('{"div_6_0",    16'h0306, 5'h10});
    vt.push_back('{"div_15_4",   16'h034F, 5'h10});
`endif
    vt.push_back('{"and",        16'h04AA, 5'h0A});
    vt.push_back('{"or",         16'h0587, 5'h0F});
    vt.push_back('{"xor",        16'h066F, 5'h09});
    vt.push_back('{"nand",       16'h0736, 5'h0D});
    vt.push_back('{"nor",        16'h0805, 5'h0A});
    vt.push_back('{"xnor",       16'h0986, 5'h01});
    vt.push_back('{"shl_3_2",    16'h0A23, 5'h0C});
    vt.push_back('{"shl_3_5",    16'h0A53, 5'h00});
    vt.push_back('{"shl_9_1",    16'h0A19, 5'h02});
    vt.push_back('{"shr_12_2",   16'h0B2C, 5'h03});
    vt.push_back('{"shr_15_4",   16'h0B4F, 5'h00});
    vt.push_back('{"gt_8_2",     16'h0C28, 5'h01});
    vt.push_back('{"gt_2_2",     16'h0C22, 5'h00});
    vt.push_back('{"lt_8_2",     16'h0D28, 5'h00});
    vt.push_back('{"lt_2_8",     16'h0D82, 5'h01});
    vt.push_back('{"eq_5_5",     16'h0E55, 5'h01});
    vt.push_back('{"eq_5_4",     16'h0E45, 5'h00});
    vt.push_back('{"inc_15",     16'h0F0F, 5'h10});
    vt.push_back('{"inc_6_hi",   16'hA0F6 | 16'h0F00, 5'h07});

    // Reset asserted with all switches up: led clears with no clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", led, 5'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held", led, 5'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_inc15", led, 5'h10);

    for (int i = 0; i < vt.size(); i++)
      apply(vt[i].name, vt[i].sw, vt[i].exp);

    // Latency: new sw between edges leaves led alone until the next rising edge.
    apply("pre_latency", 16'h0034, 5'h07);
    @(negedge clk);
    sw = 16'h0F06;
    #2;
    check("latency_hold", led, 5'h07);
    @(posedge clk);
    #1;
    check("latency_update", led, 5'h07);
    apply("latency_sub", 16'h0153, 5'h1E);
    check("latency_sub_hold_before", led, 5'h1E);

    // Upper switches alone never alter led.
    held = led;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      sw[15:12] = 4'(i);
      @(posedge clk);
      #1;
      check("upper_sw_ignored", led, held);
    end

    // Reset mid-operation, then the first edge after release loads current sw.
    apply("pre_midreset", 16'h0237, 5'h15);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_clear", led, 5'h00);
    @(negedge clk);
    sw = 16'h0089;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_reload", led, 5'h11);

    // Random sweep against the behavioural model.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] s;
      s = 16'($urandom);
      apply("random", s, model(s));
    end

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
